multicore_system_ctrl: RTL

Parametrised top-level system controller that sequences program load and execution for `NUM_CORES` CPU cores sharing one RAM. It drives the loader start, grants the shared memory port to the loader or to one core per cycle through round-robin arbitration, tracks per-core halts, and supports abort, restart-after-halt and an optional watchdog. It sits between the program loader, the cores and the memory in the system top.

---
 rtl/multicore_system_ctrl_pkg.sv | 18 +
 rtl/multicore_system_ctrl_if.sv | 39 +++
 rtl/multicore_system_ctrl_rr_arbiter.sv | 28 ++
 rtl/multicore_system_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/multicore_system_ctrl_pkg.sv
// multicore_system_ctrl_pkg: state encoding and default widths shared by the system controller files
package multicore_system_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOADING   = 3'd1,
    S_EXECUTING = 3'd2,
    S_HALTED    = 3'd3,
    S_FAULT     = 3'd4
  } state_t;
  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_MEM_ADDR_SIZE = 8;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_WDOG_WIDTH = 16;
  localparam logic [15:0] DEF_WDOG_LIMIT = 16'hFFFF;
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multicore_system_ctrl_if.sv
// multicore_system_ctrl_if: loader, core and shared-memory signals of the system controller
interface multicore_system_ctrl_if #(
  parameter int NUM_CORES = 2,
  parameter int MEM_ADDR_SIZE = 8,
  parameter int WORD_SIZE = 16
) ();
  logic start;
  logic abort;
  logic load_start;
  logic load_complete;
  logic [MEM_ADDR_SIZE-1:0] loader_addr;
  logic [WORD_SIZE-1:0] loader_wdata;
  logic loader_we;
  logic [NUM_CORES-1:0] core_req;
  logic [NUM_CORES*MEM_ADDR_SIZE-1:0] core_addr;
  logic [NUM_CORES*WORD_SIZE-1:0] core_wdata;
  logic [NUM_CORES-1:0] core_we;
  logic [NUM_CORES-1:0] core_grant;
  logic [NUM_CORES-1:0] core_execute;
  logic [NUM_CORES-1:0] core_halted;
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_write_data;
  logic mem_write;
  logic [2:0] sys_state;
  logic [NUM_CORES-1:0] halted_mask;
  logic fault;
  modport master (
    output start, abort, load_complete, loader_addr, loader_wdata, loader_we,
           core_req, core_addr, core_wdata, core_we, core_halted,
    input  load_start, core_grant, core_execute, mem_addr, mem_write_data, mem_write,
           sys_state, halted_mask, fault
  );
  modport slave (
    input  start, abort, load_complete, loader_addr, loader_wdata, loader_we,
           core_req, core_addr, core_wdata, core_we, core_halted,
    output load_start, core_grant, core_execute, mem_addr, mem_write_data, mem_write,
           sys_state, halted_mask, fault
  );
endinterface

// File: rtl/multicore_system_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first unmasked requester at or after ptr, wrapping
module rr_arbiter import multicore_system_ctrl_pkg::*; #(
  parameter int N = 2,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          grant_valid
);
  logic [PW-1:0] idx;
  logic found;
  // scan N positions starting at ptr and take the first eligible requester
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx] && !mask[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
  assign grant_valid = found;
endmodule

// File: rtl/multicore_system_ctrl.sv
// multicore_system_ctrl: sequences load/execute of NUM_CORES cores on one RAM; SYSCTRL_WATCHDOG_EN adds the FAULT watchdog
module multicore_system_ctrl import multicore_system_ctrl_pkg::*; #(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int WDOG_WIDTH = DEF_WDOG_WIDTH,
  parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(DEF_WDOG_LIMIT)
) (
  input logic clock,
  input logic reset,
  multicore_system_ctrl_if.slave bus
);
  localparam int PW = ptr_width(NUM_CORES);
  state_t state, state_d;
  logic [NUM_CORES-1:0] halted_mask, hm_d, core_execute, exec_d, req_eff, grant;
  logic [PW-1:0] rr_ptr, gidx;
  logic gv, all_halted, wd_to;
  assign req_eff = state == S_EXECUTING ? bus.core_req : '0;
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req(req_eff),
    .mask(halted_mask),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_valid(gv)
  );
  // index of the one-hot grant, used for the memory mux and pointer advance
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CORES; i++) if (grant[i]) gidx = PW'(i);
  end
  assign bus.core_grant = grant;
  assign bus.mem_addr = state == S_LOADING ? bus.loader_addr :
                        gv ? bus.core_addr[gidx*MEM_ADDR_SIZE +: MEM_ADDR_SIZE] : '0;
  assign bus.mem_write_data = state == S_LOADING ? bus.loader_wdata :
                              gv ? bus.core_wdata[gidx*WORD_SIZE +: WORD_SIZE] : '0;
  assign bus.mem_write = state == S_LOADING ? bus.loader_we : gv && bus.core_we[gidx];
  assign bus.load_start = state == S_LOADING;
  assign bus.sys_state = state;
  assign bus.halted_mask = halted_mask;
  assign bus.core_execute = core_execute;
`ifdef SYSCTRL_WATCHDOG_EN
  logic [WDOG_WIDTH-1:0] wdog;
  assign wd_to = state == S_EXECUTING && wdog == WDOG_LIMIT - 1'b1;
  assign bus.fault = state == S_FAULT;
  // count EXECUTING cycles; any other state clears it so each run starts from zero
  always_ff @(posedge clock or posedge reset)
    if (reset) wdog <= '0;
    else wdog <= state == S_EXECUTING ? wdog + 1'b1 : '0;
`else
  assign wd_to = 1'b0;
  assign bus.fault = 1'b0;
`endif
  // next state with abort > all-halted > watchdog > start/load_complete
  always_comb begin
    state_d = state;
    hm_d = halted_mask;
    all_halted = &(halted_mask | bus.core_halted);
    case (state)
      S_IDLE: if (bus.start) state_d = S_LOADING;
      S_LOADING: begin
        if (bus.abort) state_d = S_IDLE;
        else if (bus.load_complete) state_d = S_EXECUTING;
      end
      S_EXECUTING: begin
        hm_d = halted_mask | bus.core_halted;
        if (bus.abort) begin
          state_d = S_IDLE;
          hm_d = '0;
        end else if (all_halted) state_d = S_HALTED;
        else if (wd_to) state_d = S_FAULT;
      end
      S_HALTED, S_FAULT: begin
        if (bus.start) begin
          state_d = S_LOADING;
          hm_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    exec_d = state_d == S_EXECUTING ? ~hm_d : '0;
  end
  // state, halt record, run enables and round-robin pointer
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      halted_mask <= '0;
      core_execute <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_d;
      halted_mask <= hm_d;
      core_execute <= exec_d;
      rr_ptr <= gv ? (gidx == PW'(NUM_CORES - 1) ? '0 : gidx + 1'b1) : rr_ptr;
    end
endmodule
